// File: rtl/alu_seq.sv
// Nibble-serial WIDTH-bit ALU: ADD/SUB one nibble per clock with optional BCD
// correction, single-cycle logic/shift ops, start/busy/done handshake with RDY stall.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RDY,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] AI,
  input  logic [WIDTH-1:0] BI,
  input  logic             CI,
  input  logic             BCD,
  output logic [WIDTH-1:0] OUT,
  output logic             CO,
  output logic             V,
  output logic             Z,
  output logic             N,
  output logic             HC,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = $clog2(NIB);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_OR   = 4'b0010,
    OP_AND  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_PASS = 4'b0101,
    OP_ASL  = 4'b0110,
    OP_LSR  = 4'b0111,
    OP_ROL  = 4'b1000,
    OP_ROR  = 4'b1001
  } op_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ci_q, ci_d;
  logic             bcd_q, bcd_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             co_q, co_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             hc_q, hc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] bop;
  logic [WIDTH-1:0] res;
  logic [CW+1:0]    base;
  logic [4:0]       s;
  logic [3:0]       nib;
  logic             c_n;
  logic             is_arith;
  logic             last;
  logic             logic_co;

  always_comb begin
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    bop      = (op_q == OP_SUB) ? ~b_q : b_q;
    base     = {cnt_q, 2'b00};
    last     = (cnt_q == CW'(NIB - 1));
    s        = {1'b0, a_q[base +: 4]} + {1'b0, bop[base +: 4]} + {4'b0000, c_q};

    // BCD correction per nibble; SUB sees the inverted B, so s[4]=0 means borrow
    nib = s[3:0];
    c_n = s[4];
    if (bcd_q) begin
      if (op_q == OP_ADD) begin
        if (s > 5'd9) begin
          nib = s[3:0] + 4'd6;
          c_n = 1'b1;
        end else begin
          c_n = 1'b0;
        end
      end else begin
        if (!s[4]) begin
          nib = s[3:0] + 4'd10;
          c_n = 1'b0;
        end else begin
          c_n = 1'b1;
        end
      end
    end

    logic_co = ci_q;
    res      = a_q;
    if (is_arith) begin
      res = out_q;
      res[base +: 4] = nib;
    end else begin
      case (op_q)
        OP_OR:   res = a_q | b_q;
        OP_AND:  res = a_q & b_q;
        OP_XOR:  res = a_q ^ b_q;
        OP_ASL: begin
          res      = {a_q[WIDTH-2:0], 1'b0};
          logic_co = a_q[WIDTH-1];
        end
        OP_LSR: begin
          res      = {1'b0, a_q[WIDTH-1:1]};
          logic_co = a_q[0];
        end
        OP_ROL: begin
          res      = {a_q[WIDTH-2:0], ci_q};
          logic_co = a_q[WIDTH-1];
        end
        OP_ROR: begin
          res      = {ci_q, a_q[WIDTH-1:1]};
          logic_co = a_q[0];
        end
        default: res = a_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    ci_d    = ci_q;
    bcd_d   = bcd_q;
    c_d     = c_q;
    out_d   = out_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
    hc_d    = hc_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (RDY) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d    = op_t'(op);
            a_d     = AI;
            b_d     = BI;
            ci_d    = CI;
            bcd_d   = BCD;
            c_d     = CI;
            cnt_d   = '0;
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          out_d = res;
          if (is_arith) begin
            c_d   = c_n;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == '0) hc_d = c_n;
            if (last) begin
              cnt_d   = '0;
              co_d    = c_n;
              v_d     = (a_q[WIDTH-1] == bop[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
              n_d     = res[WIDTH-1];
              z_d     = (res == '0);
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            co_d    = logic_co;
            v_d     = 1'b0;
            hc_d    = 1'b0;
            n_d     = res[WIDTH-1];
            z_d     = (res == '0);
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      bcd_q   <= 1'b0;
      c_q     <= 1'b0;
      out_q   <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      hc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      bcd_q   <= bcd_d;
      c_q     <= c_d;
      out_q   <= out_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
      hc_q    <= hc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign OUT  = out_q;
  assign CO   = co_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign HC   = hc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): expectations queued at accept,
// compared with latency when done is strobed.
module tb_alu_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         RDY = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] AI = '0;
  logic [W-1:0] BI = '0;
  logic         CI = 1'b0;
  logic         BCD = 1'b0;
  logic [W-1:0] OUT;
  logic         CO, V, Z, N, HC, busy, done;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .RDY(RDY), .start(start), .op(op),
    .AI(AI), .BI(BI), .CI(CI), .BCD(BCD),
    .OUT(OUT), .CO(CO), .V(V), .Z(Z), .N(N), .HC(HC),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         co, v, z, n, hc;
    int unsigned  lat;
    int unsigned  acc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  logic        rdy_at_edge = 1'b1;
  logic        done_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] o, input logic co, v, z, n, hc,
                              input int unsigned lat);
    exp_t e;
    e.out = o; e.co = co; e.v = v; e.z = z; e.n = n; e.hc = hc;
    e.lat = lat; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, b,
                                 input logic ci, bcd);
    exp_t e;
    logic [W-1:0] bop, r;
    logic [W:0]   sum;
    logic [4:0]   lo, s;
    logic         c, hc, co, v;
    r = a; co = ci; v = 1'b0; hc = 1'b0;
    if (o == 4'd0 || o == 4'd1) begin
      bop = (o == 4'd1) ? ~b : b;
      if (!bcd) begin
        sum = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, ci};
        lo  = {1'b0, a[3:0]} + {1'b0, bop[3:0]} + {4'b0, ci};
        r = sum[W-1:0]; co = sum[W]; hc = lo[4];
      end else begin
        c = ci;
        for (int i = 0; i < W / 4; i++) begin
          s = {1'b0, a[i*4 +: 4]} + {1'b0, bop[i*4 +: 4]} + {4'b0, c};
          if (o == 4'd0) begin
            if (s > 5'd9) begin r[i*4 +: 4] = s[3:0] + 4'd6; c = 1'b1; end
            else begin r[i*4 +: 4] = s[3:0]; c = 1'b0; end
          end else begin
            if (!s[4]) begin r[i*4 +: 4] = s[3:0] + 4'd10; c = 1'b0; end
            else begin r[i*4 +: 4] = s[3:0]; c = 1'b1; end
          end
          if (i == 0) hc = c;
        end
        co = c;
      end
      v = (a[W-1] == bop[W-1]) && (r[W-1] != a[W-1]);
      return mk(r, co, v, r == '0, r[W-1], hc, W / 4);
    end
    case (o)
      4'd2: r = a | b;
      4'd3: r = a & b;
      4'd4: r = a ^ b;
      4'd6: begin r = a << 1; co = a[W-1]; end
      4'd7: begin r = a >> 1; co = a[0]; end
      4'd8: begin r = {a[W-2:0], ci}; co = a[W-1]; end
      4'd9: begin r = {ci, a[W-1:1]}; co = a[0]; end
      default: r = a;
    endcase
    return mk(r, co, 1'b0, r == '0, r[W-1], 1'b0, 1);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdy_at_edge <= RDY;
  end

  // A done that was merely held through an RDY=0 edge is not a new result
  always @(negedge clk) begin
    exp_t e;
    if (done && !(done_prev && !rdy_at_edge)) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", done, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("out",     OUT, e.out);
        chk("co",      CO,  e.co);
        chk("v",       V,   e.v);
        chk("z",       Z,   e.z);
        chk("n",       N,   e.n);
        chk("hc",      HC,  e.hc);
        chk("busy_at_done", busy, 1'b0);
        chk("latency", cyc - e.acc, e.lat);
      end
    end
    done_prev = done;
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, b,
                       input logic ci, bcd, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("busy_timeout", busy, 1'b0);
      return;
    end
    op = o; AI = a; BI = b; CI = ci; BCD = bcd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.acc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) chk("drain_timeout", sb_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] ra, rb;
    logic         rc, rd;

    repeat (2) @(negedge clk);
    chk("rst_out",  OUT,  '0);
    chk("rst_co",   CO,   1'b0);
    chk("rst_v",    V,    1'b0);
    chk("rst_z",    Z,    1'b1);
    chk("rst_n",    N,    1'b0);
    chk("rst_hc",   HC,   1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;

    issue(4'd0, 16'h1299, 16'h0001, 1'b0, 1'b1, mk(16'h1300, 0, 0, 0, 0, 1, 4));
    issue(4'd1, 16'h0000, 16'h0001, 1'b1, 1'b1, mk(16'h9999, 0, 0, 0, 1, 0, 4));
    issue(4'd1, 16'h1000, 16'h0001, 1'b1, 1'b1, mk(16'h0999, 1, 0, 0, 0, 0, 4));
    issue(4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 0, 1, 0, 1, 1, 4));
    issue(4'd0, 16'h9999, 16'h0001, 1'b0, 1'b1, mk(16'h0000, 1, 0, 1, 0, 1, 4));
    issue(4'd9, 16'h0001, 16'h0000, 1'b1, 1'b0, mk(16'h8000, 1, 0, 0, 1, 0, 1));
    issue(4'd6, 16'h8000, 16'h0000, 1'b0, 1'b0, mk(16'h0000, 1, 0, 1, 0, 0, 1));
    drain();

    // Stall after nibble 1 for three edges while start is pulsed during busy
    issue(4'd0, 16'h1234, 16'h4321, 1'b1, 1'b0, mk(16'h5556, 0, 0, 0, 0, 0, 7));
    @(negedge clk);
    op = 4'd2; AI = 16'hFFFF; BI = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    RDY = 1'b0;
    @(negedge clk);
    chk("stall_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    RDY = 1'b1;
    start = 1'b0;
    drain();

    // Reset after nibble 2 of an ADD: abort without done
    op = 4'd0; AI = 16'h5555; BI = 16'h5555; CI = 1'b0; BCD = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_out",  OUT,  '0);
    chk("abort_z",    Z,    1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    issue(4'd4, 16'hF0F0, 16'h0FF0, 1'b1, 1'b0, mk(16'hFF00, 1, 0, 0, 1, 0, 1));
    drain();

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rd = 1'($urandom);
      issue(ro, ra, rb, rc, rd, model(ro, ra, rb, rc, rd));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
